// File: rtl/m_mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM encoding, port indices
// and a one-hot helper used by the winner picker.
package m_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int PORT_IF = 0;
  localparam int PORT_DM = 1;
  localparam int NPORT   = 2;

  function automatic logic [NPORT-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/m_mem_arbiter_if.sv
// Requester + memory bus of the arbiter. slave = arbiter side,
// master = requesters and the external memory.
interface m_mem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  logic [1:0]    w_req;
  logic [1:0]    w_we;
  logic [AW-1:0] w_addr0;
  logic [AW-1:0] w_addr1;
  logic [DW-1:0] w_wdata0;
  logic [DW-1:0] w_wdata1;
  logic [1:0]    r_gnt;
  logic [1:0]    r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] w_maddr;
  logic          w_mwe;
  logic [DW-1:0] w_mdin;
  logic [DW-1:0] w_mdout;

  modport slave (
    input  w_req, w_we, w_addr0, w_addr1, w_wdata0, w_wdata1, w_mdout,
    output r_gnt, r_rvalid, r_rdata, w_maddr, w_mwe, w_mdin
  );

  modport master (
    output w_req, w_we, w_addr0, w_addr1, w_wdata0, w_wdata1, w_mdout,
    input  r_gnt, r_rvalid, r_rdata, w_maddr, w_mwe, w_mdin
  );
endinterface

// File: rtl/m_mem_arbiter_pick.sv
// Combinational winner picker. MEM_ARB_RR_EN: ties go to the port that did
// not win last; otherwise ties always go to the data port.
module m_arb_pick
  import m_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  logic tie_win;

`ifdef MEM_ARB_RR_EN
  assign tie_win = ~last;
`else
  logic unused_last;
  assign unused_last = last;
  assign tie_win     = 1'(PORT_DM);
`endif

  always_comb begin
    pick = '0;
    case (req)
      2'b01:   pick = port_onehot(1'(PORT_IF));
      2'b10:   pick = port_onehot(1'(PORT_DM));
      2'b11:   pick = port_onehot(tie_win);
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/m_mem_arbiter.sv
// Two-port (ifetch/data) arbiter for a single async-read memory: one access
// every two cycles. Tie policy selected by MEM_ARB_RR_EN (see m_arb_pick).
module m_mem_arbiter
  import m_mem_arbiter_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic             w_clk,
  input  logic             w_rst,
  m_mem_arbiter_if.slave   bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic          last_q, last_d;
  logic [1:0]    pick;
  logic          take;

  m_arb_pick u_pick (
    .req  (bus.w_req),
    .last (last_q),
    .pick (pick)
  );

  // IDLE and RESP arbitrate identically; ACCESS never accepts a new request.
  assign take = ((state_q == IDLE) || (state_q == RESP)) && (bus.w_req != 2'b00);

  always_ff @(posedge w_clk) begin
    if (w_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = take ? ACCESS : IDLE;
      ACCESS:     state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    last_d   = last_q;
    rdata_d  = rdata_q;
    gnt_d    = '0;
    rvalid_d = '0;
    if (take) begin
      gnt_d  = pick;
      last_d = pick[PORT_DM];
      if (pick[PORT_DM]) begin
        addr_d  = bus.w_addr1;
        we_d    = bus.w_we[PORT_DM];
        wdata_d = bus.w_wdata1;
      end else begin
        addr_d  = bus.w_addr0;
        we_d    = bus.w_we[PORT_IF];
        wdata_d = bus.w_wdata0;
      end
    end
    // Capture happens on the same edge as the memory write, so a write
    // returns the word it replaced.
    if (state_q == ACCESS) begin
      rvalid_d = gnt_q;
      rdata_d  = bus.w_mdout;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      last_q   <= 1'b1;
    end else begin
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      last_q   <= last_d;
    end
  end

  // Write enable is gated by reset directly so a reset landing in ACCESS
  // cannot commit the write.
  always_comb begin
    bus.w_maddr = '0;
    bus.w_mdin  = '0;
    bus.w_mwe   = 1'b0;
    if (state_q == ACCESS) begin
      bus.w_maddr = addr_q;
      bus.w_mdin  = wdata_q;
      bus.w_mwe   = we_q & ~w_rst;
    end
  end

  assign bus.r_gnt    = gnt_q;
  assign bus.r_rvalid = rvalid_q;
  assign bus.r_rdata  = rdata_q;

endmodule
